// File: rtl/mips_pkg.sv
// Shared MIPS constants and the fetch-state encoding used across the datapath slice.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_INVALID = 6'b111111;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;

    typedef enum logic [1:0] {
        FS_RUN    = 2'd0,
        FS_HALTED = 2'd1,
        FS_FAULT  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: jump target beats taken branch beats pc+4.
module pc_next_sel
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] sign_imm_i,
    input  logic [25:0] jump_idx_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    output logic [31:0] next_pc_o,
    output logic        pc_src_o
);

    logic        pc_src_s;
    logic [31:0] branch_target_s;
    logic [31:0] jump_target_s;

    assign pc_src_s        = branch_i & zero_i;
    assign branch_target_s = pc_plus4_i + {sign_imm_i[29:0], 2'b00};
    assign jump_target_s   = {pc_plus4_i[31:28], jump_idx_i, 2'b00};
    assign pc_src_o        = pc_src_s;

    // Priority mux for the PC source.
    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = jump_target_s;
        end else if (pc_src_s) begin
            next_pc_o = branch_target_s;
        end else begin
            next_pc_o = pc_plus4_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-cycle MIPS fetch stage: PC register, instruction field split,
// run/halt/fault control and a saturating retired-instruction counter.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 32'd64,
    parameter logic [31:0] HALT_WORD  = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] instr_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    output logic [29:0] imem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [5:0]  opcode_o,
    output logic [5:0]  funct_o,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  rd_o,
    output logic [31:0] sign_imm_o,
    output logic        pc_src_o,
    output logic        instr_valid_o,
    output logic        halted_o,
    output logic        fault_o,
    output logic [31:0] retired_o
);

    localparam logic [31:0] DEPTH_WORDS = IMEM_DEPTH;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  retired_q, retired_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;

    logic [31:0]  pc_plus4_s;
    logic [31:0]  sign_imm_s;
    logic [31:0]  next_pc_s;
    logic         oor_s;
    logic         hit_halt_s;
    logic         valid_s;

    assign pc_plus4_s = pc_q + 32'd4;
    assign sign_imm_s = sign_extend16(instr_i[15:0]);
    // Widen the word index so any depth up to 2^30 compares correctly.
    assign oor_s      = ({2'b00, pc_q[31:2]} >= DEPTH_WORDS);
    assign hit_halt_s = ~oor_s & (instr_i == HALT_WORD);
    assign valid_s    = (state_q == FS_RUN) & en & ~oor_s & ~hit_halt_s;

    pc_next_sel u_pc_next_sel (
        .pc_plus4_i (pc_plus4_s),
        .sign_imm_i (sign_imm_s),
        .jump_idx_i (instr_i[25:0]),
        .branch_i   (branch_i),
        .zero_i     (zero_i),
        .jump_i     (jump_i),
        .next_pc_o  (next_pc_s),
        .pc_src_o   (pc_src_o)
    );

    assign imem_addr_o   = pc_q[31:2];
    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_plus4_s;
    assign opcode_o      = valid_s ? instr_i[31:26] : OP_INVALID;
    assign funct_o       = valid_s ? instr_i[5:0] : 6'd0;
    assign rs_o          = instr_i[25:21];
    assign rt_o          = instr_i[20:16];
    assign rd_o          = instr_i[15:11];
    assign sign_imm_o    = sign_imm_s;
    assign instr_valid_o = valid_s;
    assign halted_o      = halted_q;
    assign fault_o       = fault_q;
    assign retired_o     = retired_q;

    // Next-state for PC, retire counter and the run/halt/fault machine.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        if (valid_s) begin
            pc_d = next_pc_s;
            if (retired_q != 32'hFFFF_FFFF) begin
                retired_d = retired_q + 32'd1;
            end else begin
                retired_d = retired_q;
            end
        end else begin
            pc_d      = pc_q;
            retired_d = retired_q;
        end
        case (state_q)
            FS_RUN: begin
                if (en && oor_s) begin
                    state_d = FS_FAULT;
                end else if (en && hit_halt_s) begin
                    state_d = FS_HALTED;
                end else begin
                    state_d = FS_RUN;
                end
            end
            FS_HALTED: state_d = FS_HALTED;
            FS_FAULT:  state_d = FS_FAULT;
            // An unreachable encoding is treated as a fault so fetch stops.
            default:   state_d = FS_FAULT;
        endcase
        halted_d = (state_d == FS_HALTED);
        fault_d  = (state_d == FS_FAULT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FS_RUN;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances (default depth, a high
// reset PC with full address range, and a 4-word memory) share stimulus.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, en, branch, zero, jump;
    logic [31:0] instr;

    logic [29:0] d_addr, b_addr, s_addr;
    logic [31:0] d_pc, b_pc, s_pc, d_pc4, b_pc4, s_pc4;
    logic [5:0]  d_op, b_op, s_op, d_fn, b_fn, s_fn;
    logic [4:0]  d_rs, b_rs, s_rs, d_rt, b_rt, s_rt, d_rd, b_rd, s_rd;
    logic [31:0] d_simm, b_simm, s_simm;
    logic        d_src, b_src, s_src, d_val, b_val, s_val;
    logic        d_halt, b_halt, s_halt, d_flt, b_flt, s_flt;
    logic [31:0] d_ret, b_ret, s_ret;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .en(en), .instr_i(instr), .branch_i(branch),
        .zero_i(zero), .jump_i(jump), .imem_addr_o(d_addr), .pc_o(d_pc),
        .pc_plus4_o(d_pc4), .opcode_o(d_op), .funct_o(d_fn), .rs_o(d_rs),
        .rt_o(d_rt), .rd_o(d_rd), .sign_imm_o(d_simm), .pc_src_o(d_src),
        .instr_valid_o(d_val), .halted_o(d_halt), .fault_o(d_flt), .retired_o(d_ret)
    );

    fetch_unit #(.RESET_PC(32'h2000_0040), .IMEM_DEPTH(32'h4000_0000)) dut_big (
        .clk(clk), .rst(rst), .en(en), .instr_i(instr), .branch_i(branch),
        .zero_i(zero), .jump_i(jump), .imem_addr_o(b_addr), .pc_o(b_pc),
        .pc_plus4_o(b_pc4), .opcode_o(b_op), .funct_o(b_fn), .rs_o(b_rs),
        .rt_o(b_rt), .rd_o(b_rd), .sign_imm_o(b_simm), .pc_src_o(b_src),
        .instr_valid_o(b_val), .halted_o(b_halt), .fault_o(b_flt), .retired_o(b_ret)
    );

    fetch_unit #(.IMEM_DEPTH(32'd4)) dut_small (
        .clk(clk), .rst(rst), .en(en), .instr_i(instr), .branch_i(branch),
        .zero_i(zero), .jump_i(jump), .imem_addr_o(s_addr), .pc_o(s_pc),
        .pc_plus4_o(s_pc4), .opcode_o(s_op), .funct_o(s_fn), .rs_o(s_rs),
        .rt_o(s_rt), .rd_o(s_rd), .sign_imm_o(s_simm), .pc_src_o(s_src),
        .instr_valid_o(s_val), .halted_o(s_halt), .fault_o(s_flt), .retired_o(s_ret)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; instr = 32'h0000_0000;
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (d_pc !== 32'h0 || d_ret !== 32'h0 || d_halt !== 1'b0 || d_flt !== 1'b0) begin
            $display("FAIL reset_state: pc=%h ret=%0d halt=%b flt=%b required 0/0/0/0",
                     d_pc, d_ret, d_halt, d_flt);
            errors++;
        end
        vectors++;
        if (b_pc !== 32'h2000_0040) begin
            $display("FAIL reset_pc_param: pc=%h required 20000040", b_pc);
            errors++;
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (d_pc !== 32'(4 * i) || d_ret !== 32'(i) || d_addr !== 30'(i) || d_val !== 1'b1) begin
                $display("FAIL seq_fetch[%0d]: pc=%h ret=%0d addr=%0d val=%b required %h/%0d/%0d/1",
                         i, d_pc, d_ret, d_addr, d_val, 32'(4 * i), i, i);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_fields();
        do_reset();
        instr = 32'h012A_5820;
        #1;
        vectors++;
        if (d_op !== 6'h00 || d_rs !== 5'd9 || d_rt !== 5'd10 || d_rd !== 5'd11 || d_fn !== 6'h20) begin
            $display("FAIL field_split: op=%h rs=%0d rt=%0d rd=%0d fn=%h required 00/9/10/11/20",
                     d_op, d_rs, d_rt, d_rd, d_fn);
            errors++;
        end
        instr = 32'h2128_8004;
        #1;
        vectors++;
        if (d_op !== 6'h08 || d_simm !== 32'hFFFF_8004 || d_pc4 !== 32'h4) begin
            $display("FAIL sign_imm: op=%h simm=%h pc4=%h required 08/ffff8004/00000004",
                     d_op, d_simm, d_pc4);
            errors++;
        end
    endtask

    task automatic test_branch();
        do_reset();
        repeat (4) tick();
        instr = 32'h1000_FFFE; branch = 1'b1; zero = 1'b1;
        #1;
        vectors++;
        if (d_pc !== 32'h10 || d_src !== 1'b1 || d_simm !== 32'hFFFF_FFFE) begin
            $display("FAIL beq_taken_comb: pc=%h src=%b simm=%h required 10/1/fffffffe",
                     d_pc, d_src, d_simm);
            errors++;
        end
        tick();
        vectors++;
        if (d_pc !== 32'h0C) begin
            $display("FAIL beq_taken_pc: pc=%h required 0000000c", d_pc);
            errors++;
        end
        instr = 32'h0; branch = 1'b0; zero = 1'b0;
        tick();
        instr = 32'h1000_FFFE; branch = 1'b1; zero = 1'b0;
        #1;
        vectors++;
        if (d_src !== 1'b0) begin
            $display("FAIL beq_nottaken_src: src=%b required 0", d_src);
            errors++;
        end
        tick();
        vectors++;
        if (d_pc !== 32'h14) begin
            $display("FAIL beq_nottaken_pc: pc=%h required 00000014", d_pc);
            errors++;
        end
    endtask

    task automatic test_jump_priority();
        do_reset();
        instr = 32'h0800_0010; jump = 1'b1; branch = 1'b1; zero = 1'b1;
        #1;
        vectors++;
        if (b_val !== 1'b1 || b_src !== 1'b1 || b_addr !== 30'h0800_0010) begin
            $display("FAIL jump_comb: val=%b src=%b addr=%h required 1/1/08000010",
                     b_val, b_src, b_addr);
            errors++;
        end
        tick();
        vectors++;
        if (b_pc !== 32'h2000_0040 || b_ret !== 32'd1) begin
            $display("FAIL jump_priority: pc=%h ret=%0d required 20000040/1", b_pc, b_ret);
            errors++;
        end
    endtask

    task automatic test_halt();
        do_reset();
        tick();
        tick();
        instr = 32'hFC00_0000;
        #1;
        vectors++;
        if (d_pc !== 32'h08 || d_val !== 1'b0 || d_op !== 6'b111111 || d_fn !== 6'd0) begin
            $display("FAIL halt_word_cycle: pc=%h val=%b op=%h fn=%h required 08/0/3f/00",
                     d_pc, d_val, d_op, d_fn);
            errors++;
        end
        tick();
        vectors++;
        if (d_halt !== 1'b1 || d_pc !== 32'h08 || d_op !== 6'b111111) begin
            $display("FAIL halted_state: halt=%b pc=%h op=%h required 1/08/3f", d_halt, d_pc, d_op);
            errors++;
        end
        instr = 32'h0;
        repeat (10) tick();
        vectors++;
        if (d_ret !== 32'd2 || d_pc !== 32'h08 || d_halt !== 1'b1 || d_val !== 1'b0) begin
            $display("FAIL halt_absorbing: ret=%0d pc=%h halt=%b val=%b required 2/08/1/0",
                     d_ret, d_pc, d_halt, d_val);
            errors++;
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        repeat (4) tick();
        #1;
        vectors++;
        if (s_pc !== 32'h10 || s_val !== 1'b0 || s_flt !== 1'b0 || s_op !== 6'b111111) begin
            $display("FAIL oor_cycle: pc=%h val=%b flt=%b op=%h required 10/0/0/3f",
                     s_pc, s_val, s_flt, s_op);
            errors++;
        end
        instr = 32'hFC00_0000;
        tick();
        vectors++;
        if (s_flt !== 1'b1 || s_halt !== 1'b0 || s_pc !== 32'h10 || s_ret !== 32'd4) begin
            $display("FAIL oor_fault: flt=%b halt=%b pc=%h ret=%0d required 1/0/10/4",
                     s_flt, s_halt, s_pc, s_ret);
            errors++;
        end
        instr = 32'h0;
        repeat (3) tick();
        vectors++;
        if (s_flt !== 1'b1 || s_pc !== 32'h10 || s_ret !== 32'd4) begin
            $display("FAIL fault_absorbing: flt=%b pc=%h ret=%0d required 1/10/4", s_flt, s_pc, s_ret);
            errors++;
        end
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        tick();
        tick();
        en = 1'b0;
        repeat (3) begin
            tick();
            vectors++;
            if (d_pc !== 32'h08 || d_ret !== 32'd2 || d_op !== 6'b111111 || d_val !== 1'b0) begin
                $display("FAIL stall: pc=%h ret=%0d op=%h val=%b required 08/2/3f/0",
                         d_pc, d_ret, d_op, d_val);
                errors++;
            end
        end
        en = 1'b1;
        tick();
        instr = 32'hFC00_0000;
        tick();
        vectors++;
        if (d_halt !== 1'b1 || d_pc !== 32'h0C || d_ret !== 32'd3) begin
            $display("FAIL halt_after_stall: halt=%b pc=%h ret=%0d required 1/0c/3", d_halt, d_pc, d_ret);
            errors++;
        end
        en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1; instr = 32'h0;
        #1;
        vectors++;
        if (d_pc !== 32'h0 || d_halt !== 1'b0 || d_ret !== 32'd0 || d_val !== 1'b1) begin
            $display("FAIL reset_from_halt: pc=%h halt=%b ret=%0d val=%b required 0/0/0/1",
                     d_pc, d_halt, d_ret, d_val);
            errors++;
        end
        tick();
        vectors++;
        if (d_pc !== 32'h4 || d_ret !== 32'd1) begin
            $display("FAIL run_after_reset: pc=%h ret=%0d required 4/1", d_pc, d_ret);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_fields();
        test_branch();
        test_jump_priority();
        test_halt();
        test_out_of_range();
        test_stall_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of the control unit.
- Holds the PC and drives the instruction-memory word address.
- Splits the returned instruction into opcode/funct/register/immediate fields for the control unit and register file.
- Computes next PC from the control unit's Branch/Jump and the ALU Zero flag.
- Adds a run/halt/fault state machine and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_DEPTH, 64, instruction memory size in 32-bit words; word index >= IMEM_DEPTH is out of range
HALT_WORD, 32'hFC00_0000, instruction encoding that stops fetch

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
en  in  1  fetch enable; 0 = stall
instr_i  in  32  instruction read from imem (combinational read of imem_addr_o)
branch_i  in  1  Branch from control unit
zero_i  in  1  Zero from ALU
jump_i  in  1  Jump from control unit
imem_addr_o  out  30  word address = pc[31:2]
pc_o  out  32  current PC
pc_plus4_o  out  32  pc + 4
opcode_o  out  6  instr[31:26], or 6'b111111 when not valid
funct_o  out  6  instr[5:0], or 0 when not valid
rs_o, rt_o, rd_o  out  5 each  instr[25:21], [20:16], [15:11]
sign_imm_o  out  32  sign-extended instr[15:0]
pc_src_o  out  1  branch_i & zero_i
instr_valid_o  out  1  current instruction executes this cycle
halted_o  out  1  state == HALTED
fault_o  out  1  state == FAULT
retired_o  out  32  count of valid instructions

Behaviour:
- Reset values: pc = RESET_PC; state = RUN; retired_o = 0; halted_o = 0; fault_o = 0.
- All outputs except state-derived flags are combinational from pc/instr_i.
- oor = (pc[31:2] >= IMEM_DEPTH). hit_halt = ~oor & (instr_i == HALT_WORD).
- instr_valid_o = (state == RUN) & en & ~oor & ~hit_halt.
- When ~instr_valid_o, opcode_o is forced to 6'b111111 and funct_o to 0. The control unit's default case then asserts no writes.
- Next PC, evaluated only when instr_valid_o:
  - jump_i = 1: {pc_plus4[31:28], instr_i[25:0], 2'b00}. Jump has priority over branch.
  - else branch_i & zero_i = 1: pc_plus4 + (sign_imm << 2).
  - else: pc_plus4.
- All PC arithmetic is modulo 2^32; wrap past 32'hFFFF_FFFC is silent.
- pc holds whenever ~instr_valid_o.
- States:
  - RUN: oor & en -> FAULT. Else hit_halt & en -> HALTED. Else stay. The oor check has precedence over halt.
  - HALTED: absorbing; pc holds; exit only by rst.
  - FAULT: absorbing; pc holds at the offending address; exit only by rst.
- en = 0: no PC, state or counter change.
- retired_o increments by 1 on each clock edge with instr_valid_o = 1. It saturates at 32'hFFFF_FFFF.
- The halt word itself is not counted.
- rst in any state or mid-stall: the next edge restores all reset values; rst overrides en.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_ADDI 6'b001000, OP_BEQ 6'b000100, OP_J 6'b000010, OP_INVALID 6'b111111.
  - funct constants: add, sub, slt, mul.
  - fetch state enum {RUN, HALTED, FAULT}.
- One sub-module, pc_next_sel: purely combinational next-PC/target mux (pc_plus4, sign_imm, instr[25:0], branch, zero, jump -> next_pc, pc_src).
- The FSM and counter stay in fetch_unit.

Test Plan:
1. Reset and sequential fetch: rst 2 cycles, en=1, NOP instrs -> pc_o 0,4,8,12 on successive cycles; retired_o 0,1,2,3; imem_addr_o 0,1,2,3.
2. BEQ taken: pc=0x10, imm=16'hFFFE, branch=1, zero=1 -> pc_src_o=1, next pc=0x0C. With zero=0 -> pc_src_o=0, next pc=0x14.
3. Jump priority: pc=0x2000_0040, instr=0x0800_0010, jump=1 and branch=zero=1 -> next pc=0x2000_0040.
4. Halt: HALT_WORD at 0x08 -> pc holds 0x08 and instr_valid_o=0 in that cycle; halted_o=1 next cycle; opcode_o=6'b111111; retired_o stays 2 for 10 cycles.
5. Out of range: IMEM_DEPTH=4, straight-line code -> at pc=0x10, fault_o=1 next cycle; pc stays 0x10; retired_o=4.
6. Stall and reset: en=0 for 3 cycles at pc=0x08 -> pc and retired_o frozen, opcode_o=6'b111111. Then rst pulse while HALTED -> pc=0, state RUN, retired_o=0.
